painterengine_gpu_dma_reader_mc: RTL and testbench

//  Multi-channel, parametrised AXI4 burst read DMA for the PainterEngine GPU; next generation of the single-job reader.

---
 rtl/painterengine_gpu_dma_pkg.sv | 29 ++
 rtl/painterengine_gpu_rr_arbiter.sv | 34 +++
 rtl/painterengine_gpu_dma_reader_mc.sv | 243 ++++++++++++++++++++++++
 tb/tb_painterengine_gpu_dma_reader_mc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared definitions for the PainterEngine GPU multi-channel AXI read DMA:
// FSM states, error codes, AXI field constants and a constant clog2 helper.
package painterengine_gpu_dma_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ARB, ST_CHECK, ST_CALC, ST_ADDR,
        ST_DATA, ST_DRAIN, ST_DONE, ST_ERROR, ST_HALT
    } state_e;

    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_PARAM = 3'd1;
    localparam logic [2:0] ERR_RRESP = 3'd2;
    localparam logic [2:0] ERR_RLAST = 3'd3;
    localparam logic [2:0] ERR_AR_TO = 3'd4;
    localparam logic [2:0] ERR_R_TO  = 3'd5;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/painterengine_gpu_rr_arbiter.sv
// Round-robin picker: lowest requester at or above ptr+1, wrapping around.
module painterengine_gpu_rr_arbiter
    import painterengine_gpu_dma_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    int c;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_o = 1'b0;
        c       = 0;
        for (int i = 1; i <= N; i++) begin
            c = int'(ptr_i) + i;
            if (c >= N) c = c - N;
            if (en_i && !found_o && req_i[c]) begin
                found_o    = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/painterengine_gpu_dma_reader_mc.sv
// Multi-channel AXI4 burst read DMA: round-robin job arbitration, bursts clipped
// to MAX_BURST and 4 KB pages, RRESP/RLAST checking and response timeouts.
module painterengine_gpu_dma_reader_mc
    import painterengine_gpu_dma_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 32,
    parameter int MAX_BURST = 256,
    parameter int TIMEOUT_W = 19
) (
    input  logic                      i_wire_clock,
    input  logic                      i_wire_reset,
    input  logic [NUM_CH-1:0]         i_wire_start,
    input  logic [NUM_CH*ADDR_W-1:0]  i_wire_address,
    input  logic [NUM_CH*LEN_W-1:0]   i_wire_length,
    output logic [NUM_CH-1:0]         o_wire_busy,
    output logic [NUM_CH-1:0]         o_wire_done,
    output logic [NUM_CH-1:0]         o_wire_error,
    output logic [2:0]                o_wire_error_type,
    output logic                      o_wire_fatal,
    output logic [DATA_W-1:0]         o_wire_data,
    output logic [NUM_CH-1:0]         o_wire_data_valid,
    input  logic [NUM_CH-1:0]         i_wire_data_next,
    output logic [3:0]                o_wire_M_AXI_ARID,
    output logic [ADDR_W-1:0]         o_wire_M_AXI_ARADDR,
    output logic [7:0]                o_wire_M_AXI_ARLEN,
    output logic [2:0]                o_wire_M_AXI_ARSIZE,
    output logic [1:0]                o_wire_M_AXI_ARBURST,
    output logic                      o_wire_M_AXI_ARLOCK,
    output logic [3:0]                o_wire_M_AXI_ARCACHE,
    output logic [2:0]                o_wire_M_AXI_ARPROT,
    output logic [3:0]                o_wire_M_AXI_ARQOS,
    output logic                      o_wire_M_AXI_ARVALID,
    input  logic                      i_wire_M_AXI_ARREADY,
    input  logic [DATA_W-1:0]         i_wire_M_AXI_RDATA,
    input  logic [1:0]                i_wire_M_AXI_RRESP,
    input  logic                      i_wire_M_AXI_RLAST,
    input  logic                      i_wire_M_AXI_RVALID,
    output logic                      o_wire_M_AXI_RREADY
);

    localparam int BSZ = clog2(DATA_W / 8);
    localparam int IW  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int OW  = LEN_W + 1;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   busy_q, busy_d, grant_q, grant_d;
    logic [IW-1:0]       gidx_q, gidx_d, rr_q, rr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, araddr_q, araddr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [OW-1:0]       off_q, off_d;
    logic [8:0]          burst_q, burst_d, beat_q, beat_d;
    logic [TIMEOUT_W-1:0] to_q, to_d;
    logic [2:0]          etype_q, etype_d;
    logic                fatal_q, fatal_d;

    logic [NUM_CH-1:0]   arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                arb_found;
    logic [ADDR_W-1:0]   cur_addr;
    logic [OW-1:0]       remain, off_next, bmin;
    logic [12:0]         page_beats;
    logic                rready, r_hs, ar_hs, last_beat, wait_st, tmo;

    painterengine_gpu_rr_arbiter #(.N(NUM_CH), .IW(IW)) u_arb (
        .req_i   (busy_q),
        .ptr_i   (rr_q),
        .en_i    (state_q == ST_ARB),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .found_o (arb_found)
    );

    assign cur_addr   = addr_q + (ADDR_W'(off_q) << BSZ);
    assign remain     = {1'b0, len_q} - off_q;
    assign page_beats = (13'h1000 - {1'b0, cur_addr[11:0]}) >> BSZ;
    assign rready     = (state_q == ST_DATA) ? i_wire_data_next[gidx_q] : (state_q == ST_DRAIN);
    assign r_hs       = i_wire_M_AXI_RVALID & rready;
    assign ar_hs      = (state_q == ST_ADDR) & i_wire_M_AXI_ARREADY;
    assign last_beat  = (beat_q == burst_q - 9'd1);
    assign off_next   = off_q + OW'(burst_q);
    assign wait_st    = state_q inside {ST_ADDR, ST_DATA, ST_DRAIN};
    assign tmo        = to_q[TIMEOUT_W-1];

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= '0;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_q     <= '0;
            addr_q   <= '0;
            araddr_q <= '0;
            len_q    <= '0;
            off_q    <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            to_q     <= '0;
            etype_q  <= ERR_OK;
            fatal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            araddr_q <= araddr_d;
            len_q    <= len_d;
            off_q    <= off_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            to_q     <= to_d;
            etype_q  <= etype_d;
            fatal_q  <= fatal_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q | i_wire_start;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        araddr_d = araddr_q;
        len_d    = len_q;
        off_d    = off_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        etype_d  = etype_q;
        fatal_d  = fatal_q;
        bmin     = remain;
        if ({3'b0, page_beats} < bmin) bmin = OW'(page_beats);
        if (OW'(MAX_BURST) < bmin)     bmin = OW'(MAX_BURST);
        unique case (state_q)
            ST_IDLE: if (|busy_q) state_d = ST_ARB;
            ST_ARB: begin
                if (arb_found) begin
                    grant_d = arb_grant;
                    gidx_d  = arb_idx;
                    rr_d    = arb_idx;
                    addr_d  = i_wire_address[arb_idx*ADDR_W +: ADDR_W];
                    len_d   = i_wire_length[arb_idx*LEN_W +: LEN_W];
                    off_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (addr_q[BSZ-1:0] != '0 || len_q == '0) begin
                    etype_d = ERR_PARAM;
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                burst_d  = 9'(bmin);
                araddr_d = cur_addr;
                beat_d   = '0;
                state_d  = ST_ADDR;
            end
            ST_ADDR: begin
                if (tmo) begin
                    etype_d = ERR_AR_TO;
                    fatal_d = 1'b1;
                    state_d = ST_ERROR;
                end else if (i_wire_M_AXI_ARREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tmo) begin
                    etype_d = ERR_R_TO;
                    fatal_d = 1'b1;
                    state_d = ST_ERROR;
                end else if (r_hs) begin
                    beat_d = beat_q + 9'd1;
                    // A bad beat that already carries RLAST ends the burst, so no drain is needed.
                    if (i_wire_M_AXI_RRESP != AXI_RESP_OKAY) begin
                        etype_d = ERR_RRESP;
                        state_d = i_wire_M_AXI_RLAST ? ST_ERROR : ST_DRAIN;
                    end else if (i_wire_M_AXI_RLAST && !last_beat) begin
                        etype_d = ERR_RLAST;
                        state_d = ST_ERROR;
                    end else if (!i_wire_M_AXI_RLAST && last_beat) begin
                        etype_d = ERR_RLAST;
                        state_d = ST_DRAIN;
                    end else if (last_beat) begin
                        off_d   = off_next;
                        state_d = (off_next == {1'b0, len_q}) ? ST_DONE : ST_CALC;
                    end
                end
            end
            ST_DRAIN: begin
                if (tmo) begin
                    etype_d = ERR_R_TO;
                    fatal_d = 1'b1;
                    state_d = ST_ERROR;
                end else if (r_hs && i_wire_M_AXI_RLAST) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE: begin
                busy_d  = busy_d & ~grant_q;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                busy_d  = busy_d & ~grant_q;
                state_d = fatal_q ? ST_HALT : ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q || ar_hs || r_hs) to_d = '0;
        else if (wait_st)                        to_d = to_q + TIMEOUT_W'(1);
        else                                     to_d = to_q;
    end

    assign o_wire_busy          = busy_q;
    assign o_wire_done          = (state_q == ST_DONE)  ? grant_q : '0;
    assign o_wire_error         = (state_q == ST_ERROR) ? grant_q : '0;
    assign o_wire_error_type    = (state_q == ST_ERROR) ? etype_q : ERR_OK;
    assign o_wire_fatal         = fatal_q;
    assign o_wire_data          = i_wire_M_AXI_RDATA;
    assign o_wire_data_valid    = (state_q == ST_DATA && i_wire_M_AXI_RVALID) ? grant_q : '0;
    assign o_wire_M_AXI_ARID    = 4'd0;
    assign o_wire_M_AXI_ARADDR  = araddr_q;
    assign o_wire_M_AXI_ARLEN   = burst_q[7:0] - 8'd1;
    assign o_wire_M_AXI_ARSIZE  = 3'(BSZ);
    assign o_wire_M_AXI_ARBURST = AXI_BURST_INCR;
    assign o_wire_M_AXI_ARLOCK  = 1'b0;
    assign o_wire_M_AXI_ARCACHE = AXI_CACHE_BUF;
    assign o_wire_M_AXI_ARPROT  = 3'd0;
    assign o_wire_M_AXI_ARQOS   = 4'd0;
    assign o_wire_M_AXI_ARVALID = (state_q == ST_ADDR);
    assign o_wire_M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader_mc.sv
// Directed bench: job vector table against a small AXI read slave model,
// plus hand sequences for reset mid-burst, round-robin order and timeout.
module tb_painterengine_gpu_dma_reader_mc;

    localparam int M_OK = 0, M_RRESP = 1, M_EARLY = 2, M_MISS = 3;

    logic clk, rst;
    logic [3:0]   start, busy, done, error, dvalid, dnext;
    logic [127:0] addr_flat, len_flat;
    logic [2:0]   etype, arsize, arprot;
    logic         fatal, arlock, arvalid, arready, rlast, rvalid, rready;
    logic [31:0]  data, araddr, rdata;
    logic [3:0]   arid, arcache, arqos;
    logic [7:0]   arlen;
    logic [1:0]   arburst, rresp;

    painterengine_gpu_dma_reader_mc #(
        .NUM_CH(4), .DATA_W(32), .ADDR_W(32), .LEN_W(32), .MAX_BURST(256), .TIMEOUT_W(8)
    ) dut (
        .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start),
        .i_wire_address(addr_flat), .i_wire_length(len_flat),
        .o_wire_busy(busy), .o_wire_done(done), .o_wire_error(error),
        .o_wire_error_type(etype), .o_wire_fatal(fatal), .o_wire_data(data),
        .o_wire_data_valid(dvalid), .i_wire_data_next(dnext),
        .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
        .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst), .o_wire_M_AXI_ARLOCK(arlock),
        .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
        .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
        .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp), .i_wire_M_AXI_RLAST(rlast),
        .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int n_pass = 0, n_tot = 0;
    int mode = M_OK;
    bit tog = 0, ar_en = 1;

    logic [31:0] ar_log_a[$], cap_d[$], q_addr[$];
    int          ar_log_l[$], cap_ch[$], q_len[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // AXI read slave: decides handshakes from values captured just before the previous posedge.
    initial begin
        bit p_arv, p_arr, p_rv, p_rr, p_rl;
        logic [31:0] p_ara;
        int p_arl, rbeat, nb, cyc;
        p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0; p_rl = 0; p_ara = 0; p_arl = 0;
        rbeat = 0; cyc = 0;
        arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = 0; dnext = 4'hF;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_addr.delete(); q_len.delete(); rbeat = 0;
            end else begin
                if (p_arv && p_arr) begin
                    q_addr.push_back(p_ara); q_len.push_back(p_arl);
                    ar_log_a.push_back(p_ara); ar_log_l.push_back(p_arl);
                end
                if (p_rv && p_rr) begin
                    if (p_rl) begin
                        void'(q_addr.pop_front()); void'(q_len.pop_front()); rbeat = 0;
                    end else rbeat++;
                end
            end
            cyc++;
            arready = ar_en;
            dnext = tog ? {4{cyc[0]}} : 4'hF;
            if (q_len.size() > 0) begin
                nb     = (mode == M_MISS) ? q_len[0] + 2 : (mode == M_EARLY) ? 2 : q_len[0] + 1;
                rvalid = 1;
                rdata  = q_addr[0] + 32'(4 * rbeat);
                rlast  = (rbeat == nb - 1);
                rresp  = (mode == M_RRESP && rbeat == 1) ? 2'd2 : 2'd0;
            end else begin
                rvalid = 0; rlast = 0; rresp = 0;
            end
            #1;
            p_arv = arvalid && !rst; p_arr = arready; p_ara = araddr; p_arl = int'(arlen);
            p_rv = rvalid && !rst; p_rr = rready; p_rl = rlast;
            for (int c = 0; c < 4; c++)
                if (dvalid[c] && dnext[c]) begin
                    cap_ch.push_back(c); cap_d.push_back(data);
                end
        end
    end

    typedef struct {
        int ch; logic [31:0] addr; logic [31:0] len; int mode; bit tog;
        int etype; int nar; logic [31:0] a0, a1, a2; int l0, l1, l2;
    } vec_t;

    task automatic clear_logs();
        ar_log_a.delete(); ar_log_l.delete(); cap_ch.delete(); cap_d.delete();
    endtask

    task automatic run_job(input vec_t v, input bit chk_lat);
        int k, lat, bad;
        bit got;
        logic [3:0] d, e;
        logic [2:0] et;
        logic [20:0] arf;
        logic [31:0] ea[3];
        int el[3];
        ea = '{v.a0, v.a1, v.a2};
        el = '{v.l0, v.l1, v.l2};
        clear_logs();
        mode = v.mode; tog = v.tog;
        addr_flat[v.ch*32 +: 32] = v.addr;
        len_flat[v.ch*32 +: 32]  = v.len;
        start = 4'(1 << v.ch);
        lat = -1; got = 0; k = 0; d = 0; e = 0; et = 0; arf = 0;
        while (!got && k < 4000) begin
            tick(); k++; start = '0;
            if (lat < 0 && arvalid) begin
                lat = k;
                arf = {arid, arsize, arburst, arlock, arcache, arprot, arqos};
            end
            if ((done | error) != 0) begin
                got = 1; d = done; e = error; et = etype;
            end
        end
        chk("job_end", got, 1);
        if (v.etype == 0) chk("done_vec", {d, e}, {4'(1 << v.ch), 4'b0});
        else              chk("err_vec", {d, e, et}, {4'b0, 4'(1 << v.ch), 3'(v.etype)});
        tick();
        chk("busy_clr", busy[v.ch], 0);
        chk("ar_count", ar_log_a.size(), v.nar);
        for (int i = 0; i < v.nar && i < ar_log_a.size(); i++) begin
            chk("ar_addr", ar_log_a[i], ea[i]);
            chk("ar_len", ar_log_l[i], el[i]);
        end
        if (v.etype == 0) begin
            bad = 0;
            for (int i = 0; i < cap_d.size(); i++)
                if (cap_d[i] !== v.addr + 32'(4 * i) || cap_ch[i] != v.ch) bad++;
            chk("beat_cnt", cap_d.size(), v.len);
            chk("beat_data", bad, 0);
        end
        if (chk_lat) begin
            chk("latency", lat, 5);
            chk("ar_fields", arf, {4'd0, 3'd2, 2'd1, 1'b0, 4'd2, 3'd0, 4'd0});
        end
    endtask

    task automatic pulse_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        vec_t tv[9];
        int k;
        bit got;
        int order[4];
        logic [3:0] rem[4];
        tv[0] = '{1, 32'h1000, 4,   M_OK,    0, 0, 1, 32'h1000, 0, 0, 3, 0, 0};
        tv[1] = '{0, 32'h0FF8, 10,  M_OK,    0, 0, 2, 32'h0FF8, 32'h1000, 0, 1, 7, 0};
        tv[2] = '{2, 32'h0,    600, M_OK,    1, 0, 3, 32'h0, 32'h400, 32'h800, 255, 255, 87};
        tv[3] = '{3, 32'h1002, 4,   M_OK,    0, 1, 0, 0, 0, 0, 0, 0, 0};
        tv[4] = '{0, 32'h0,    0,   M_OK,    0, 1, 0, 0, 0, 0, 0, 0, 0};
        tv[5] = '{1, 32'h2000, 4,   M_RRESP, 0, 2, 1, 32'h2000, 0, 0, 3, 0, 0};
        tv[6] = '{2, 32'h3000, 4,   M_EARLY, 0, 3, 1, 32'h3000, 0, 0, 3, 0, 0};
        tv[7] = '{3, 32'h3000, 4,   M_MISS,  0, 3, 1, 32'h3000, 0, 0, 3, 0, 0};
        tv[8] = '{0, 32'h2FF0, 300, M_OK,    0, 0, 3, 32'h2FF0, 32'h3000, 32'h3400, 3, 255, 39};

        rst = 1; start = 0; addr_flat = 0; len_flat = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {done, error, dvalid}, 0);
        chk("rst_axi", {arvalid, rready}, 0);
        chk("rst_fatal_type", {fatal, etype}, 0);
        rst = 0;

        for (int i = 0; i < 9; i++) run_job(tv[i], i == 0);

        // Reset while a long burst is streaming, then all channels at once.
        clear_logs(); mode = M_OK; tog = 0;
        addr_flat[64 +: 32] = 0; len_flat[64 +: 32] = 600; start = 4'b0100;
        tick(); start = 0;
        repeat (30) tick();
        chk("mid_beats_seen", cap_d.size() > 0, 1);
        pulse_reset();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_outs", {arvalid, rready, dvalid, done, error, fatal}, 0);

        clear_logs();
        for (int c = 0; c < 4; c++) begin
            addr_flat[c*32 +: 32] = 32'h4000 + 32'(c * 32'h100);
            len_flat[c*32 +: 32]  = 4;
        end
        order = '{1, 2, 3, 0};
        rem   = '{4'b1101, 4'b1001, 4'b0001, 4'b0000};
        start = 4'b1111; tick(); start = 0; tick();
        start = 4'b0001; tick(); start = 0;
        for (int j = 0; j < 4; j++) begin
            got = 0; k = 0;
            while (!got && k < 300) begin
                if ((done | error) != 0) got = 1;
                else begin tick(); k++; end
            end
            chk("rr_done", {done, error}, {4'(1 << order[j]), 4'b0});
            tick();
            chk("rr_busy", busy, rem[j]);
        end
        repeat (20) tick();
        chk("restart_ignored", {busy, 4'(ar_log_a.size())}, {4'b0, 4'd4});

        // ARREADY held low: address-phase timeout, sticky fatal until reset.
        ar_en = 0;
        addr_flat[32 +: 32] = 32'h5000; len_flat[32 +: 32] = 4; start = 4'b0010;
        got = 0; k = 0;
        while (!got && k < 600) begin
            tick(); k++; start = 0;
            if ((done | error) != 0) got = 1;
        end
        chk("to_err", {done, error, etype}, {4'b0, 4'b0010, 3'd4});
        chk("to_fatal", fatal, 1);
        repeat (5) tick();
        chk("halt_outs", {fatal, arvalid, rready}, 3'b100);
        pulse_reset();
        chk("fatal_clr", fatal, 0);
        ar_en = 1;
        run_job(tv[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
